carfield_domain_rst_ctrl: RTL and testbench

Per-domain reset/isolation sequencer for the Carfield power/reset domains: periphery, safety island, security island, integer cluster, FP cluster and L2. It takes software- or debugger-issued reset requests from the Carfield register file and serves them one at a time with round-robin fairness. For each granted domain it runs a fixed sequence: isolate the domain's AXI ports, gate its clock, pulse its reset, restore its clock, then de-isolate. It sits between the Carfield register block and the per-domain clock-gate, reset and AXI-isolation cells.

---
 rtl/carfield_domain_rst_ctrl_pkg.sv | 42 ++++
 rtl/carfield_domain_rst_ctrl_rr_arb.sv | 45 ++++
 rtl/carfield_domain_rst_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_carfield_domain_rst_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/carfield_domain_rst_ctrl_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the domain reset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package carfield_domain_rst_ctrl_pkg;

    // Reset domains, in the bit order used by every per-domain vector.
    localparam int unsigned NumDomains = 6;

    typedef enum logic [2:0] {
        DOM_PERIPH      = 3'd0,
        DOM_SAFETY      = 3'd1,
        DOM_SECURITY    = 3'd2,
        DOM_INT_CLUSTER = 3'd3,
        DOM_FP_CLUSTER  = 3'd4,
        DOM_L2          = 3'd5
    } carfield_domain_e;

    localparam int unsigned DefaultRstHoldCycles    = 16;
    localparam int unsigned DefaultIsoTimeoutCycles = 1024;

    // Length of the short fixed steps (clock off, reset assert, reset release).
    localparam int unsigned FixedStateCycles = 2;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ISO         = 3'd1,
        ST_CLK_OFF     = 3'd2,
        ST_RST_ASSERT  = 3'd3,
        ST_CLK_ON      = 3'd4,
        ST_RST_RELEASE = 3'd5,
        ST_DEISO       = 3'd6,
        ST_DONE        = 3'd7
    } domain_rst_state_e;

    // Down-counter must hold the largest reload value of either wait.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/carfield_domain_rst_ctrl_rr_arb.sv
// Round-robin request picker: first set request at or after i_ptr, wrapping around.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a grant is actually taken.
//
// Ports:
//   i_req  request vector (one bit per requester)
//   i_ptr  index where the priority search starts
//   o_vld  at least one request is set
//   o_gnt  one-hot grant
//   o_idx  binary index of the granted requester
module carfield_domain_rst_ctrl_rr_arb #(
    parameter int unsigned NumReq = 6,
    parameter int unsigned IdxW   = 3
) (
    input  logic [NumReq-1:0] i_req,
    input  logic [IdxW-1:0]   i_ptr,
    output logic              o_vld,
    output logic [NumReq-1:0] o_gnt,
    output logic [IdxW-1:0]   o_idx
);

    always_comb begin
        int unsigned      w_sum;
        logic [IdxW-1:0]  w_pos;
        o_vld = 1'b0;
        o_gnt = '0;
        o_idx = '0;
        w_sum = 0;
        w_pos = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            // Rotate the search so i_ptr has the highest priority.
            w_sum = 32'(i_ptr) + i;
            if (w_sum >= NumReq) begin
                w_sum = w_sum - NumReq;
            end
            w_pos = IdxW'(w_sum);
            if (!o_vld && i_req[w_pos]) begin
                o_vld        = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
            end
        end
    end

endmodule

// File: rtl/carfield_domain_rst_ctrl.sv
// Per-domain reset/isolation sequencer: isolate, clock off, reset pulse, clock on, de-isolate.
// Latency: request to isolate_o is 2 cycles; full sequence with immediate acks is 11+RstHoldCycles to idle.
// Backpressure: requests queue in a pending bit per domain; one domain served at a time, round-robin.
//
// Ports:
//   clk_i, rst_ni    clock and asynchronous active-low reset
//   rst_req_i        per-domain single-cycle reset request
//   isolate_o        AXI isolation request, isolated_i its level ack
//   clk_en_o         domain clock-gate enable
//   domain_rst_no    domain reset, active-low
//   done_o           one-cycle pulse at the end of a domain's sequence
//   iso_timeout_o    sticky: an isolation handshake for that domain timed out
//   busy_o           sequencer is not idle
module carfield_domain_rst_ctrl
    import carfield_domain_rst_ctrl_pkg::*;
#(
    parameter int unsigned RstHoldCycles    = DefaultRstHoldCycles,
    parameter int unsigned IsoTimeoutCycles = DefaultIsoTimeoutCycles
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumDomains-1:0] rst_req_i,
    output logic [NumDomains-1:0] isolate_o,
    input  logic [NumDomains-1:0] isolated_i,
    output logic [NumDomains-1:0] clk_en_o,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic [NumDomains-1:0] done_o,
    output logic [NumDomains-1:0] iso_timeout_o,
    output logic                  busy_o
);

    localparam int unsigned IdxW = $clog2(NumDomains);
    localparam int unsigned CntW = cnt_width(RstHoldCycles, IsoTimeoutCycles);

    // Counter reload values: a state lasting N cycles loads N-1 and leaves at zero.
    localparam logic [CntW-1:0] IsoLoad  = CntW'(IsoTimeoutCycles - 1);
    localparam logic [CntW-1:0] HoldLoad = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0] FixLoad  = CntW'(FixedStateCycles - 1);

    domain_rst_state_e     r_state;
    logic [CntW-1:0]       r_cnt;
    logic [IdxW-1:0]       r_sel;
    logic [IdxW-1:0]       r_ptr;
    logic [NumDomains-1:0] r_pending;
    logic [NumDomains-1:0] r_isolate;
    logic [NumDomains-1:0] r_clk_en;
    logic [NumDomains-1:0] r_rst_n;
    logic [NumDomains-1:0] r_done;
    logic [NumDomains-1:0] r_timeout;
    logic                  r_busy;

    logic                  w_gnt_vld;
    logic [NumDomains-1:0] w_gnt_oh;
    logic [IdxW-1:0]       w_gnt_idx;
    logic [IdxW-1:0]       w_ptr_nxt;
    logic [NumDomains-1:0] w_pend_clr;
    logic                  w_cnt_zero;
    logic                  w_iso_ack;

    carfield_domain_rst_ctrl_rr_arb #(
        .NumReq (NumDomains),
        .IdxW   (IdxW)
    ) u_rr_arb (
        .i_req (r_pending),
        .i_ptr (r_ptr),
        .o_vld (w_gnt_vld),
        .o_gnt (w_gnt_oh),
        .o_idx (w_gnt_idx)
    );

    // Next search starts just after the domain being granted.
    assign w_ptr_nxt  = (w_gnt_idx == IdxW'(NumDomains - 1)) ? '0 : w_gnt_idx + IdxW'(1);
    assign w_pend_clr = ((r_state == ST_IDLE) && w_gnt_vld) ? w_gnt_oh : '0;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_iso_ack  = isolated_i[r_sel];

    // OR-ing the request after the clear lets a same-cycle request survive the grant,
    // which also covers a re-request of the domain currently in service.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | rst_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_isolate <= '0;
            r_clk_en  <= '1;
            r_rst_n   <= '1;
            r_done    <= '0;
            r_timeout <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_vld) begin
                        r_sel                <= w_gnt_idx;
                        r_ptr                <= w_ptr_nxt;
                        r_timeout[w_gnt_idx] <= 1'b0;
                        r_isolate[w_gnt_idx] <= 1'b1;
                        r_busy               <= 1'b1;
                        r_cnt                <= IsoLoad;
                        r_state              <= ST_ISO;
                    end
                end
                ST_ISO: begin
                    // An ack in the final wait cycle still counts as a clean handshake.
                    if (w_iso_ack || w_cnt_zero) begin
                        if (!w_iso_ack) begin
                            r_timeout[r_sel] <= 1'b1;
                        end
                        r_clk_en[r_sel] <= 1'b0;
                        r_cnt           <= FixLoad;
                        r_state         <= ST_CLK_OFF;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                ST_CLK_OFF: begin
                    if (w_cnt_zero) begin
                        r_rst_n[r_sel] <= 1'b0;
                        r_cnt          <= FixLoad;
                        r_state        <= ST_RST_ASSERT;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                ST_RST_ASSERT: begin
                    if (w_cnt_zero) begin
                        r_clk_en[r_sel] <= 1'b1;
                        r_cnt           <= HoldLoad;
                        r_state         <= ST_CLK_ON;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                ST_CLK_ON: begin
                    if (w_cnt_zero) begin
                        r_rst_n[r_sel] <= 1'b1;
                        r_cnt          <= FixLoad;
                        r_state        <= ST_RST_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                ST_RST_RELEASE: begin
                    if (w_cnt_zero) begin
                        r_isolate[r_sel] <= 1'b0;
                        r_cnt            <= IsoLoad;
                        r_state          <= ST_DEISO;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                ST_DEISO: begin
                    if (!w_iso_ack || w_cnt_zero) begin
                        if (w_iso_ack) begin
                            r_timeout[r_sel] <= 1'b1;
                        end
                        r_done[r_sel] <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign isolate_o     = r_isolate;
    assign clk_en_o      = r_clk_en;
    assign domain_rst_no = r_rst_n;
    assign done_o        = r_done;
    assign iso_timeout_o = r_timeout;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_carfield_domain_rst_ctrl.sv
// Self-checking bench for the domain reset sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_carfield_domain_rst_ctrl;

    localparam int H  = 16;
    localparam int TO = 8;
    localparam int NV = 12 + H;

    logic       clk;
    logic       rst_n;
    logic [5:0] rst_req;
    logic [5:0] isolate;
    logic [5:0] isolated;
    logic [5:0] clk_en;
    logic [5:0] dom_rst_n;
    logic [5:0] done;
    logic [5:0] iso_to;
    logic       busy;
    logic [5:0] iso_block;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Isolate-cell model: acks in the same cycle unless blocked.
    assign isolated = isolate & ~iso_block;

    carfield_domain_rst_ctrl #(
        .RstHoldCycles    (H),
        .IsoTimeoutCycles (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rst_req_i     (rst_req),
        .isolate_o     (isolate),
        .isolated_i    (isolated),
        .clk_en_o      (clk_en),
        .domain_rst_no (dom_rst_n),
        .done_o        (done),
        .iso_timeout_o (iso_to),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0] req;
        logic [5:0] iso;
        logic [5:0] clk_en;
        logic [5:0] rst_n;
        logic [5:0] done;
        logic [5:0] iso_to;
        logic       busy;
    } vec_t;

    vec_t vecs [NV];
    int   order[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        int s, e, d, r;
        bit saw_done, saw_busy, saw_iso;

        // Expected trace for one request of domain 3, cycle 0 = request cycle.
        for (int c = 0; c < NV; c++) begin
            vecs[c].req    = (c == 0) ? 6'b001000 : 6'b000000;
            vecs[c].iso    = (c >= 2 && c <= 8 + H) ? 6'b001000 : 6'b000000;
            vecs[c].clk_en = (c >= 3 && c <= 6) ? 6'b110111 : 6'b111111;
            vecs[c].rst_n  = (c >= 5 && c <= 6 + H) ? 6'b110111 : 6'b111111;
            vecs[c].done   = (c == 10 + H) ? 6'b001000 : 6'b000000;
            vecs[c].iso_to = 6'b000000;
            vecs[c].busy   = (c >= 2 && c <= 10 + H);
        end

        rst_n     = 1'b0;
        rst_req   = '0;
        iso_block = '0;
        tick(); tick(); tick();
        check("rst_isolate", isolate, 6'h00);
        check("rst_clk_en", clk_en, 6'h3F);
        check("rst_dom_rst_n", dom_rst_n, 6'h3F);
        check("rst_done", done, 6'h00);
        check("rst_iso_to", iso_to, 6'h00);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(); tick();

        // Single request, full trace.
        for (int c = 0; c < NV; c++) begin
            check($sformatf("seq_isolate_c%0d", c), isolate, vecs[c].iso);
            check($sformatf("seq_clk_en_c%0d", c), clk_en, vecs[c].clk_en);
            check($sformatf("seq_rst_n_c%0d", c), dom_rst_n, vecs[c].rst_n);
            check($sformatf("seq_done_c%0d", c), done, vecs[c].done);
            check($sformatf("seq_iso_to_c%0d", c), iso_to, vecs[c].iso_to);
            check($sformatf("seq_busy_c%0d", c), busy, vecs[c].busy);
            rst_req = vecs[c].req;
            tick();
        end
        rst_req = '0;

        // Serve domain 1 so the pointer sits at 2, then contend 1, 4, 5.
        rst_req = 6'b000010; tick(); rst_req = '0;
        for (int k = 0; k < 60 && !done[1]; k++) tick();
        check("prep_done1_seen", done[1], 1);
        tick();
        rst_req = 6'b110010; tick(); rst_req = '0;
        order.delete();
        for (int k = 0; k < 100; k++) begin
            for (int b = 0; b < 6; b++) if (done[b]) order.push_back(b);
            tick();
        end
        check("rr_done_count", order.size(), 3);
        check("rr_first", (order.size() > 0) ? order[0] : 99, 4);
        check("rr_second", (order.size() > 1) ? order[1] : 99, 5);
        check("rr_third", (order.size() > 2) ? order[2] : 99, 1);
        check("rr_idle_after", busy, 0);

        // Isolation timeout on domain 2.
        iso_block = 6'b000100;
        rst_req = 6'b000100; tick(); rst_req = '0;
        for (int k = 0; k < 10 && !isolate[2]; k++) tick();
        check("to_iso_seen", isolate[2], 1);
        s = cyc;
        for (int k = 0; k < 30 && clk_en[2]; k++) tick();
        e = cyc;
        check("to_iso_len", e - s, TO);
        check("to_flag_set", iso_to, 6'b000100);
        iso_block = '0;
        for (int k = 0; k < 60 && !done[2]; k++) tick();
        check("to_done_seen", done[2], 1);
        tick(); tick();
        check("to_flag_sticky", iso_to, 6'b000100);
        rst_req = 6'b000100; tick(); rst_req = '0;
        for (int k = 0; k < 10 && !isolate[2]; k++) tick();
        check("to_regrant_seen", isolate[2], 1);
        check("to_flag_cleared", iso_to, 6'b000000);
        for (int k = 0; k < 60 && !done[2]; k++) tick();
        check("to_done2_seen", done[2], 1);
        tick(); tick();

        // Re-request domain 0 while it is in CLK_ON.
        rst_req = 6'b000001; tick(); rst_req = '0;
        for (int k = 0; k < 20 && !(clk_en[0] && !dom_rst_n[0]); k++) tick();
        check("rr0_clk_on_seen", {31'd0, clk_en[0] && !dom_rst_n[0]}, 1);
        rst_req = 6'b000001; tick(); rst_req = '0;
        for (int k = 0; k < 60 && !done[0]; k++) tick();
        check("rr0_done1_seen", done[0], 1);
        d = cyc;
        tick();
        check("rr0_idle_gap_busy", busy, 0);
        for (int k = 0; k < 10 && !isolate[0]; k++) tick();
        r = cyc;
        check("rr0_restart_gap", r - d, 2);
        for (int k = 0; k < 60 && !done[0]; k++) tick();
        check("rr0_done2_seen", done[0], 1);
        tick(); tick();
        check("rr0_idle_end", busy, 0);

        // Reset during RST_ASSERT of domain 5, with domain 1 pending.
        rst_req = 6'b100000; tick(); rst_req = '0;
        for (int k = 0; k < 20 && !(!clk_en[5] && !dom_rst_n[5]); k++) tick();
        check("mr_rst_assert_seen", {31'd0, !clk_en[5] && !dom_rst_n[5]}, 1);
        rst_req = 6'b000010; tick(); rst_req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("mr_isolate", isolate, 6'h00);
        check("mr_clk_en", clk_en, 6'h3F);
        check("mr_dom_rst_n", dom_rst_n, 6'h3F);
        check("mr_busy", busy, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("mr_busy_after", busy, 0);
        saw_done = 0; saw_busy = 0; saw_iso = 0;
        for (int k = 0; k < 60; k++) begin
            if (done != 0) saw_done = 1;
            if (busy) saw_busy = 1;
            if (isolate != 0) saw_iso = 1;
            tick();
        end
        check("mr_no_done", {31'd0, saw_done}, 0);
        check("mr_no_busy", {31'd0, saw_busy}, 0);
        check("mr_no_isolate", {31'd0, saw_iso}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
